prio_index_decoder: RTL and testbench
=====================================

# prio_index_decoder

Sequential counterpart of `priority_enc`. It accepts a stream of encoded indices, each an `(idx, none)` pair in the same format that `priority_enc` produces, over a valid/ready handshake. It decodes each index to one-hot, ORs it into a frame mask, and presents the finished mask with a set-bit count and error flags when the frame's last beat arrives. It sits downstream of encoder-based scanners and rebuilds the request vector they consumed.

## Interface
- `N`, default 8: mask width, 2 ≤ N ≤ 256.
- `W`, default `$clog2(N)`: index width. Derived; do not override.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block can accept a beat.
- `in_idx` input W: encoded bit index; 0 is the LSB.
- `in_none` input 1: beat carries no index. Overrides `in_idx`.
- `in_last` input 1: final beat of the frame.
- `out_valid` output 1: frame result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_mask` output N: OR of one-hot decodes in the frame.
- `out_count` output `$clog2(N+1)`: number of set bits in `out_mask`.
- `out_dup` output 1: at least one index repeated within the frame.
- `out_range` output 1: at least one `in_idx` ≥ N within the frame (possible only when N is not a power of 2).

## Operation
- Two-state FSM: ACCUM and HOLD.
- Reset (asynchronous assert, synchronous release) sets:
  - state = ACCUM
  - `out_mask` = 0, `out_count` = 0, `out_dup` = 0, `out_range` = 0
  - `out_valid` = 0
  - `in_ready` is low only while `rst_n` is low; it goes to 1 in the first cycle after release.
- ACCUM:
  - `in_ready` = 1, `out_valid` = 0.
  - A beat is accepted when `in_valid & in_ready`.
  - Accepted beat with `in_none` = 1: no change to mask, count or flags, except that `in_last` still ends the frame.
  - Accepted beat with `in_none` = 0 and `in_idx` < N:
    - if mask bit `in_idx` is already set: `out_dup` ← 1, mask and count unchanged;
    - otherwise: set the bit and `out_count` += 1.
  - Accepted beat with `in_none` = 0 and `in_idx` ≥ N: `out_range` ← 1, mask unchanged.
  - Accepted beat with `in_last` = 1: apply the beat's update as above, then go to HOLD.
- HOLD:
  - `in_ready` = 0, `out_valid` = 1.
  - `out_mask`, `out_count`, `out_dup` and `out_range` hold stable.
  - On `out_ready` = 1: clear mask, count and both flags, and return to ACCUM.
- `out_count` is maintained incrementally, never by a combinational popcount of the mask. It therefore always equals popcount(`out_mask`), with a maximum of N.
- A frame may be a single beat (`in_last` on the first beat). An all-`none` frame yields mask 0, count 0.
- Mask, count and flags are visible while in ACCUM; they are only meaningful while `out_valid` = 1.

## Timing
- Latency: the result is valid in the cycle after the edge that accepts the last beat.
- Throughput: one beat per cycle within a frame. There is one mandatory bubble per frame: at least one HOLD cycle, during which `in_ready` = 0.
- HOLD with `out_ready` already high lasts exactly one cycle. `in_ready` returns to 1 in the next cycle.
- `out_valid` must not drop, and outputs must not change, until the handshake completes.
- `in_ready` is a pure function of state and has no combinational path from `out_ready`.
- Reset asserted mid-frame or in HOLD: the partial frame and the pending result are discarded, and all outputs take their reset values immediately.

## Test plan
- Reset, then the beats idx 0, 3, 7 with last on 7, `out_ready` = 1:
  - `out_valid` high for exactly 1 cycle, 1 cycle after the last beat;
  - `out_mask` = 8'b1000_1001, `out_count` = 3, `out_dup` = 0.
- Beats 5, 5, 2 (last):
  - `out_mask` = 8'b0010_0100, `out_count` = 2, `out_dup` = 1.
- Single beat `in_none` = 1, `in_last` = 1:
  - `out_mask` = 0, `out_count` = 0, both flags 0;
  - a following frame {1 (last)} gives mask 8'b0000_0010 with flags cleared.
- Backpressure: hold `out_ready` = 0 for 5 cycles after a frame {6 (last)}:
  - `out_valid` stays 1, `out_mask` = 8'b0100_0000 stays stable, `in_ready` = 0 throughout;
  - the next frame is accepted only after the handshake.
- With N = 6: beats idx 6, 2 (last):
  - `out_range` = 1, `out_mask` = 6'b000100, `out_count` = 1.
- Random: 256 frames of random length 1–10 with random `in_valid` and `out_ready`. Each result must match a model that ORs the decoded indices, with count equal to popcount of the mask. Assert `rst_n` in the middle of a frame: outputs must go to 0 immediately and the next frame must start clean.

Source files
------------

// File: rtl/prio_index_decoder.sv
// prio_index_decoder: rebuilds a request mask from a stream of encoded indices.
// Each accepted beat is decoded to one-hot and ORed into a frame mask. A running
// set-bit count and duplicate/out-of-range flags are kept alongside. The frame
// result is presented with a valid/ready handshake once the last beat arrives.
module prio_index_decoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_idx,
    input  logic                   in_none,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_mask,
    output logic [$clog2(N+1)-1:0] out_count,
    output logic                   out_dup,
    output logic                   out_range
);

    localparam int CW = $clog2(N+1);
    // Widened by one bit so the out-of-range compare also works for N = 2**W.
    localparam logic [W:0] N_LIM = (W+1)'(N);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          started;
    logic [N-1:0]  mask_q, mask_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dup_q, dup_d;
    logic          rng_q, rng_d;

    logic          accept;
    logic          in_bound;
    logic [N-1:0]  hot;
    logic          hit;

    assign accept   = in_valid & in_ready;
    assign in_bound = ({1'b0, in_idx} < N_LIM);
    assign hot      = {{(N-1){1'b0}}, 1'b1} << in_idx;
    assign hit      = |(mask_q & hot);

    // in_ready depends only on registered state, so there is no path from out_ready.
    assign in_ready  = started & (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign out_mask  = mask_q;
    assign out_count = cnt_q;
    assign out_dup   = dup_q;
    assign out_range = rng_q;

    // Next-state and next-frame-contents logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
        state_nxt = state;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        dup_d     = dup_q;
        rng_d     = rng_q;
        unique case (state)
            ACCUM: begin
                if (accept) begin
                    if (!in_none) begin
                        if (!in_bound) begin
                            rng_d = 1'b1;
                        end else if (hit) begin
                            dup_d = 1'b1;
                        end else begin
                            mask_d = mask_q | hot;
                            cnt_d  = cnt_q + CW'(1);
                        end
                    end
                    if (in_last) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    mask_d    = '0;
                    cnt_d     = '0;
                    dup_d     = 1'b0;
                    rng_d     = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // State, frame contents and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            started <= 1'b0;
            mask_q  <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state   <= state_nxt;
            started <= 1'b1;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            dup_q   <= dup_d;
            rng_q   <= rng_d;
        end
    end

endmodule

// File: tb/tb_prio_index_decoder.sv
// Self-checking bench for prio_index_decoder: directed frame table, handshake
// corner cases, an N=6 range case, and randomized frames against a model.
module tb_prio_index_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // N = 8 instance
    logic       v, rdy, none, last, ov, ordy, dup, rng;
    logic [2:0] idx;
    logic [7:0] mask;
    logic [3:0] cnt;

    prio_index_decoder #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v), .in_ready(rdy), .in_idx(idx), .in_none(none), .in_last(last),
        .out_valid(ov), .out_ready(ordy), .out_mask(mask), .out_count(cnt),
        .out_dup(dup), .out_range(rng)
    );

    // N = 6 instance
    logic       v6, rdy6, none6, last6, ov6, ordy6, dup6, rng6;
    logic [2:0] idx6;
    logic [5:0] mask6;
    logic [2:0] cnt6;

    prio_index_decoder #(.N(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v6), .in_ready(rdy6), .in_idx(idx6), .in_none(none6), .in_last(last6),
        .out_valid(ov6), .out_ready(ordy6), .out_mask(mask6), .out_count(cnt6),
        .out_dup(dup6), .out_range(rng6)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one beat at a negedge and return at the negedge after it is accepted.
    task automatic drive_beat(input logic [2:0] i, input logic n, input logic l);
        int guard;
        v = 1'b1; idx = i; none = n; last = l;
        guard = 0;
        while (!rdy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", guard);
        end
        @(negedge clk);
        v = 1'b0; last = 1'b0; none = 1'b0;
    endtask

    typedef struct packed {
        logic [2:0]       len;
        logic [3:0][2:0]  idx;
        logic [3:0]       none;
        logic [7:0]       mask;
        logic [3:0]       cnt;
        logic             dup;
    } vec_t;

    function automatic vec_t mk(input int len, input int i0, input int i1, input int i2,
                                input int i3, input logic [3:0] nb, input logic [7:0] m,
                                input int c, input logic d);
        vec_t r;
        r.len    = 3'(len);
        r.idx[0] = 3'(i0);
        r.idx[1] = 3'(i1);
        r.idx[2] = 3'(i2);
        r.idx[3] = 3'(i3);
        r.none   = nb;
        r.mask   = m;
        r.cnt    = 4'(c);
        r.dup    = d;
        return r;
    endfunction

    vec_t vecs[7];

    // Reset in the middle of a frame or during HOLD: outputs clear at once.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(ov), 32'd0);
        check({tag, "_rst_mask"},  32'(mask), 32'd0);
        check({tag, "_rst_count"}, 32'(cnt), 32'd0);
        check({tag, "_rst_ready"}, 32'(rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] m_mask;
        logic       m_dup;
        logic [7:0] held;
        int         len, gap, hold;
        logic [2:0] ri;
        logic       rn;

        v = 0; idx = 0; none = 0; last = 0; ordy = 1;
        v6 = 0; idx6 = 0; none6 = 0; last6 = 0; ordy6 = 1;

        vecs[0] = mk(3, 0, 3, 7, 0, 4'b0000, 8'b1000_1001, 3, 1'b0);
        vecs[1] = mk(3, 5, 5, 2, 0, 4'b0000, 8'b0010_0100, 2, 1'b1);
        vecs[2] = mk(1, 0, 0, 0, 0, 4'b0001, 8'b0000_0000, 0, 1'b0);
        vecs[3] = mk(1, 1, 0, 0, 0, 4'b0000, 8'b0000_0010, 1, 1'b0);
        vecs[4] = mk(4, 7, 6, 5, 4, 4'b0000, 8'b1111_0000, 4, 1'b0);
        vecs[5] = mk(3, 7, 2, 7, 0, 4'b0101, 8'b0000_0100, 1, 1'b0);
        vecs[6] = mk(4, 0, 0, 0, 0, 4'b0000, 8'b0000_0001, 1, 1'b1);

        // Reset state
        #12;
        check("reset_ready", 32'(rdy), 32'd0);
        check("reset_valid", 32'(ov), 32'd0);
        check("reset_mask",  32'(mask), 32'd0);
        check("reset_count", 32'(cnt), 32'd0);
        check("reset_flags", {30'd0, dup, rng}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(rdy), 32'd1);

        // Directed frame table, out_ready held high
        for (int k = 0; k < 7; k++) begin
            for (int b = 0; b < int'(vecs[k].len); b++)
                drive_beat(vecs[k].idx[b], vecs[k].none[b], b == int'(vecs[k].len) - 1);
            check($sformatf("v%0d_valid", k), 32'(ov), 32'd1);
            check($sformatf("v%0d_ready_hold", k), 32'(rdy), 32'd0);
            check($sformatf("v%0d_mask", k), 32'(mask), 32'(vecs[k].mask));
            check($sformatf("v%0d_count", k), 32'(cnt), 32'(vecs[k].cnt));
            check($sformatf("v%0d_dup", k), 32'(dup), 32'(vecs[k].dup));
            check($sformatf("v%0d_range", k), 32'(rng), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_valid_drop", k), 32'(ov), 32'd0);
            check($sformatf("v%0d_ready_back", k), 32'(rdy), 32'd1);
            check($sformatf("v%0d_cleared", k), {mask, 4'd0, cnt, 14'd0, dup, rng}, 32'd0);
        end

        // Backpressure: frame {6 (last)} held for 5 cycles while a beat waits
        ordy = 1'b0;
        drive_beat(3'd6, 1'b0, 1'b1);
        v = 1'b1; idx = 3'd3; last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_valid_%0d", c), 32'(ov), 32'd1);
            check($sformatf("bp_mask_%0d", c), 32'(mask), 32'h40);
            check($sformatf("bp_ready_%0d", c), 32'(rdy), 32'd0);
            @(negedge clk);
        end
        v = 1'b0; last = 1'b0;
        ordy = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", 32'(ov), 32'd0);
        drive_beat(3'd3, 1'b0, 1'b1);
        check("bp_next_mask", 32'(mask), 32'h08);
        check("bp_next_count", 32'(cnt), 32'd1);
        @(negedge clk);

        // N = 6: index 6 is out of range
        v6 = 1'b1; idx6 = 3'd6; last6 = 1'b0;
        @(negedge clk);
        idx6 = 3'd2; last6 = 1'b1;
        @(negedge clk);
        v6 = 1'b0; last6 = 1'b0;
        check("n6_valid", 32'(ov6), 32'd1);
        check("n6_range", 32'(rng6), 32'd1);
        check("n6_mask",  32'(mask6), 32'b000100);
        check("n6_count", 32'(cnt6), 32'd1);
        check("n6_dup",   32'(dup6), 32'd0);
        @(negedge clk);
        check("n6_valid_drop", 32'(ov6), 32'd0);
        check("n6_range_clear", 32'(rng6), 32'd0);

        // Random frames against a model
        for (int f = 0; f < 256; f++) begin
            if (f == 100) begin
                drive_beat(3'd1, 1'b0, 1'b0);
                drive_beat(3'd6, 1'b0, 1'b0);
                pulse_reset("midframe");
            end
            if (f == 200) begin
                ordy = 1'b0;
                drive_beat(3'd5, 1'b0, 1'b1);
                pulse_reset("hold");
            end
            ordy = 1'(($urandom & 1));
            len = int'($urandom_range(1, 10));
            m_mask = 8'd0;
            m_dup = 1'b0;
            for (int b = 0; b < len; b++) begin
                gap = int'($urandom_range(0, 2));
                repeat (gap) @(negedge clk);
                ri = 3'($urandom_range(0, 7));
                rn = ($urandom_range(0, 4) == 0);
                if (!rn) begin
                    if (m_mask[ri]) m_dup = 1'b1;
                    m_mask[ri] = 1'b1;
                end
                drive_beat(ri, rn, b == len - 1);
            end
            ordy = 1'b0;
            check($sformatf("r%0d_valid", f), 32'(ov), 32'd1);
            check($sformatf("r%0d_mask", f), 32'(mask), 32'(m_mask));
            check($sformatf("r%0d_count", f), 32'(cnt), 32'($countones(m_mask)));
            check($sformatf("r%0d_dup", f), 32'(dup), 32'(m_dup));
            held = mask;
            hold = int'($urandom_range(0, 3));
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                check($sformatf("r%0d_hold_valid", f), 32'(ov), 32'd1);
                check($sformatf("r%0d_hold_mask", f), 32'(mask), 32'(held));
            end
            ordy = 1'b1;
            @(negedge clk);
            check($sformatf("r%0d_valid_drop", f), 32'(ov), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
